// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared state encoding and default width for the sequential prime checker
package prime_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BOUND,
      DIV,
      EVAL,
      DONE
   } state_t;

   localparam int DEFAULT_N = 8;

endpackage

// File: rtl/mod_unit.sv
// rtl/mod_unit.sv - restoring remainder unit, one dividend bit per cycle
module mod_unit #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem,
   output logic         valid
);

   localparam int CW = $clog2(N + 1);

   logic [N-1:0]  rem_q;
   logic [N-1:0]  shreg;
   logic [N-1:0]  div_q;
   logic [CW-1:0] cnt;
   logic          active;

   function automatic logic [N-1:0] step(input logic [N-1:0] r, input logic b,
                                         input logic [N-1:0] dv);
      logic [N:0] t;
      t = {r, b};
      if (t >= {1'b0, dv}) begin
         t = t - {1'b0, dv};
      end
      return t[N-1:0];
   endfunction

   // The MSB is consumed on the start edge itself so the final remainder is
   // ready after N edges counting the start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         shreg  <= '0;
         div_q  <= '0;
         cnt    <= '0;
         active <= 1'b0;
         valid  <= 1'b0;
      end else if (start) begin
         rem_q  <= step('0, dividend[N-1], divisor);
         shreg  <= dividend << 1;
         div_q  <= divisor;
         cnt    <= CW'(N - 1);
         active <= 1'b1;
         valid  <= 1'b0;
      end else if (active) begin
         rem_q <= step(rem_q, shreg[N-1], div_q);
         shreg <= shreg << 1;
         cnt   <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            active <= 1'b0;
            valid  <= 1'b1;
         end
      end else begin
         valid <= 1'b0;
      end
   end

   assign rem = rem_q;

endmodule

// File: rtl/prime_seq_checker.sv
// rtl/prime_seq_checker.sv - trial-division primality tester with start/busy/done handshake
import prime_pkg::*;

module prime_seq_checker #(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   output logic         busy,
   output logic         done,
   output logic         is_prime,
   output logic [N-1:0] factor
);

   state_t         state;
   logic [N-1:0]   a_q;
   logic [N-1:0]   d;
   logic [2*N-1:0] sq;
   logic           sq_over;
   logic           mod_start;
   logic [N-1:0]   mod_rem;
   logic           mod_valid;

   // Full 2N-bit square so the bound test can never overflow.
   assign sq        = {{N{1'b0}}, d} * {{N{1'b0}}, d};
   assign sq_over   = sq > {{N{1'b0}}, a_q};
   assign mod_start = (state == BOUND) && !sq_over;

   mod_unit #(.N(N)) u_mod (
      .clk      (clk),
      .rst      (rst),
      .start    (mod_start),
      .dividend (a_q),
      .divisor  (d),
      .rem      (mod_rem),
      .valid    (mod_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         d        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         is_prime <= 1'b0;
         factor   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q      <= a;
                  is_prime <= 1'b0;
                  factor   <= '0;
                  if (a < N'(2)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     d     <= N'(2);
                     state <= BOUND;
                  end
               end
            end
            BOUND: begin
               if (sq_over) begin
                  is_prime <= 1'b1;
                  factor   <= a_q;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  state <= DIV;
               end
            end
            DIV: begin
               if (mod_valid) begin
                  state <= EVAL;
               end
            end
            EVAL: begin
               if (mod_rem == '0) begin
                  is_prime <= 1'b0;
                  factor   <= d;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  d     <= d + N'(1);
                  state <= BOUND;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/prime_seq_checker.md
Name: prime_seq_checker

Overview:
- Sequential, parametrised-width primality tester. It is the clocked successor to the combinational prime checker.
- Checks trial divisors d = 2, 3, 4, … while d*d <= a. Each remainder is computed with an N-cycle restoring remainder unit.
- Reports is_prime and the smallest nontrivial factor through a start/busy/done handshake.
- Intended for operand widths where a combinational % chain is too large.

Parameters:
- N, 8, operand width in bits (N >= 2, even recommended)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  N  operand; latched on an accepted start
- busy  output  1  high from the edge after accept until the edge that enters DONE
- done  output  1  one-cycle pulse; results valid from this cycle
- is_prime  output  1  1 if a >= 2 and no divisor was found
- factor  output  N  smallest divisor > 1; a itself if prime; 0 if a < 2

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, is_prime=0, factor=0, internal d=0, operand register=0. Reset mid-operation aborts and discards the computation.
- States:
  - IDLE: start=1 latches a and sets busy=1.
    - If a<2 → DONE.
    - Otherwise d=2 → BOUND.
  - BOUND: compare d*d (2N-bit product, no overflow) against a.
    - If d*d > a → DONE with is_prime=1, factor=a.
    - Otherwise pulse mod_unit start → DIV.
  - DIV: wait exactly N cycles for mod_unit valid → EVAL.
  - EVAL: if rem==0 → DONE with is_prime=0, factor=d. Otherwise d=d+1 → BOUND.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Outputs is_prime and factor are registered and hold until the next accepted start. They are cleared in the accept cycle.
- Latency, counted in edges from the accepting edge to the DONE cycle (T = number of completed trials):
  - a<2: 1
  - prime: T*(N+2)+2
  - composite, factor found on trial T: T*(N+2)+1
- start while busy or in DONE: ignored, with no effect on a, d or outputs.
- start held high continuously: a new operation is accepted in each IDLE cycle. This gives back-to-back operation with one IDLE cycle between ops.
- d width is N bits; the bound check guarantees d <= 2^(N/2)+1, so d never wraps.
- a=2 or 3: T=0, prime, latency 2.

Decomposition:
- Package prime_pkg holds:
  - state enum {IDLE, BOUND, DIV, EVAL, DONE}
  - localparam for the default width
- Sub-module mod_unit #(N):
  - Ports: clk, rst, start, dividend[N], divisor[N] → rem[N], valid.
  - Restoring remainder, one dividend bit per cycle.
  - valid pulses exactly N edges after start.
  - Divisor 0 is never issued by the parent.

Test Plan (N=8):
1. a=97, start pulse → done after 82 edges (T=8), is_prime=1, factor=97; busy high throughout.
2. a=91 → done after 61 edges (T=6), is_prime=0, factor=7.
3. a=1 and then a=0 → done after 1 edge each, is_prime=0, factor=0. a=2 → done after 2 edges, is_prime=1, factor=2.
4. a=255 → done after 21 edges, factor=3. a=4 → done after 11 edges, factor=2.
5. Start a=97, change a to 4 and pulse start at edge 10 → start ignored; result still prime, factor=97, latency 82.
6. Start a=251, assert rst at edge 30 → immediately busy=0, done=0, outputs 0. After release, a=9 → done after 21 edges, factor=3, with no residue from the aborted run.
